// File: rtl/bus_arbiter_if.sv
// Bus-ownership handshake between the datapath masters and the round-robin arbiter.
// The masters drive requests and locks; the arbiter returns the registered grant view.
interface bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) ();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] lock;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             bus_busy;
    logic             preempt;

    modport master (
        output req,
        output lock,
        input  grant,
        input  grant_id,
        input  bus_busy,
        input  preempt
    );

    modport slave (
        input  req,
        input  lock,
        output grant,
        output grant_id,
        output bus_busy,
        output preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit tristate bus: registered one-hot
// grants, a forced one-cycle turnaround between owners, and bounded hold with lock.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N_REQ - 1);
    localparam logic [ID_W-1:0]   ID_ONE    = ID_W'(1);
    localparam logic [N_REQ-1:0]  BIT0      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // First asserted request scanning ptr, ptr+1, ... with wrap. The scan runs from
    // the farthest offset down so the nearest requester is the last one written.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [ID_W-1:0]  p
    );
        logic [ID_W-1:0] w;
        logic [ID_W-1:0] sel;
        w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sel = ID_W'((int'(p) + i) % N_REQ);
            w   = r[sel] ? sel : w;
        end
        return w;
    endfunction

    state_t             state_r;
    logic [N_REQ-1:0]   grant_r;
    logic [ID_W-1:0]    grant_id_r;
    logic               bus_busy_r;
    logic               preempt_r;
    logic [ID_W-1:0]    ptr_r;
    logic [HOLD_W-1:0]  hold_cnt_r;

    logic               any_req_s;
    logic               owner_req_s;
    logic               owner_lock_s;
    logic               others_req_s;
    logic               timeout_s;
    logic [ID_W-1:0]    winner_s;
    logic [ID_W-1:0]    next_ptr_s;

    // Arbitration decode; grant_r only ever holds the owner bit while in ST_OWN.
    always_comb begin
        any_req_s    = |bus.req;
        winner_s     = rr_pick(bus.req, ptr_r);
        next_ptr_s   = (winner_s == ID_LAST) ? '0 : (winner_s + ID_ONE);
        owner_req_s  = bus.req[grant_id_r];
        owner_lock_s = bus.lock[grant_id_r];
        others_req_s = |(bus.req & ~grant_r);
        timeout_s    = (hold_cnt_r == HOLD_LAST);
    end

    // Ownership FSM with all bus-facing outputs registered on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            grant_id_r <= '0;
            bus_busy_r <= 1'b0;
            preempt_r  <= 1'b0;
            ptr_r      <= '0;
            hold_cnt_r <= '0;
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_TURN: begin
                    if (any_req_s) begin
                        grant_r    <= BIT0 << winner_s;
                        grant_id_r <= winner_s;
                        bus_busy_r <= 1'b1;
                        ptr_r      <= next_ptr_s;
                        hold_cnt_r <= '0;
                        state_r    <= ST_OWN;
                    end else begin
                        grant_r    <= '0;
                        grant_id_r <= '0;
                        bus_busy_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (!owner_req_s) begin
                        grant_r    <= '0;
                        grant_id_r <= '0;
                        bus_busy_r <= 1'b0;
                        state_r    <= ST_TURN;
                    end else if (timeout_s && others_req_s && !owner_lock_s) begin
                        grant_r    <= '0;
                        grant_id_r <= '0;
                        bus_busy_r <= 1'b0;
                        preempt_r  <= 1'b1;
                        state_r    <= ST_TURN;
                    end else begin
                        // Saturate so a lone or locked owner keeps the bus indefinitely.
                        hold_cnt_r <= timeout_s ? hold_cnt_r : (hold_cnt_r + HOLD_ONE);
                        state_r    <= ST_OWN;
                    end
                end
                default: begin
                    grant_r    <= '0;
                    grant_id_r <= '0;
                    bus_busy_r <= 1'b0;
                    hold_cnt_r <= '0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = grant_r;
    assign bus.grant_id = grant_id_r;
    assign bus.bus_busy = bus_busy_r;
    assign bus.preempt  = preempt_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus a
// randomized run checked each cycle against an owner/ptr/cycle-count model.
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bus_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

    bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, for how many cycles, and where the scan starts.
    int         m_owner;
    int         m_ptr;
    int         m_owned;
    logic       m_pre;
    logic       m_others;
    logic [3:0] m_r;
    logic [3:0] m_l;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_owned = 0;
            m_pre   = 1'b0;
        end else begin
            m_r   = bus.req;
            m_l   = bus.lock;
            m_pre = 1'b0;
            if (m_owner >= 0) begin
                m_others = (m_r & ~(4'b0001 << m_owner)) != 4'b0000;
                if (!m_r[m_owner]) begin
                    m_owner = -1;
                end else if (m_owned >= MAX_HOLD && m_others && !m_l[m_owner]) begin
                    m_owner = -1;
                    m_pre   = 1'b1;
                end else begin
                    m_owned++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && m_r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                if (m_owner >= 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owned = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [3:0] eg;
        logic [1:0] eid;
        if (rst === 1'b1) begin
            eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            eid = (m_owner >= 0) ? m_owner[1:0] : 2'd0;
            check("model_grant",    32'(bus.grant),    32'(eg));
            check("model_grant_id", 32'(bus.grant_id), 32'(eid));
            check("model_bus_busy", 32'(bus.bus_busy), 32'(eg != 4'b0000));
            check("model_preempt",  32'(bus.preempt),  32'(m_pre));
            check("onehot0_grant",  32'($onehot0(bus.grant)), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",    32'(bus.grant),    32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_bus_busy", 32'(bus.bus_busy), 32'd0);
        check("rst_preempt",  32'(bus.preempt),  32'd0);
        rst = 1'b1;
    endtask

    initial begin
        int         cnt;
        int         bad;
        logic [3:0] r;
        logic [3:0] l;
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;

        // Scenario 1 and 2: first grant and voluntary handover.
        do_reset();
        bus.req = 4'b0110;
        step();
        check("s1_grant",    32'(bus.grant),    32'h2);
        check("s1_grant_id", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0100;
        step();
        check("s2_turn_grant", 32'(bus.grant), 32'h0);
        step();
        check("s2_next_grant", 32'(bus.grant), 32'h4);
        bus.req = 4'b0000;
        step();

        // Scenario 3: two held requesters alternate on hold timeout.
        do_reset();
        bus.req = 4'b0011;
        step();
        cnt = 0;
        while (bus.grant == 4'b0001 && cnt < 20) begin
            cnt++;
            step();
        end
        check("s3_hold_cycles",   32'(cnt),         32'd8);
        check("s3_preempt_pulse", 32'(bus.preempt), 32'd1);
        check("s3_turn_grant",    32'(bus.grant),   32'h0);
        step();
        check("s3_m1_grant",   32'(bus.grant),   32'h2);
        check("s3_pulse_gone", 32'(bus.preempt), 32'd0);
        repeat (8) step();
        check("s3_m1_preempt", 32'(bus.preempt), 32'd1);
        step();
        check("s3_m0_again", 32'(bus.grant), 32'h1);

        // Scenario 4: lock on the owner suppresses preemption until released.
        do_reset();
        bus.lock = 4'b0001;
        bus.req  = 4'b0011;
        step();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.grant != 4'b0001 || bus.preempt) bad++;
            step();
        end
        check("s4_locked_hold", 32'(bad), 32'd0);
        bus.lock = 4'b0000;
        step();
        check("s4_unlock_preempt", 32'(bus.preempt), 32'd1);
        check("s4_unlock_grant",   32'(bus.grant),   32'h0);

        // Scenario 5: a single requester is never preempted.
        do_reset();
        bus.req = 4'b1000;
        step();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.grant != 4'b1000 || bus.preempt) bad++;
            step();
        end
        check("s5_single_owner", 32'(bad), 32'd0);

        // Scenario 6: asynchronous reset mid-grant also returns the pointer to 0.
        do_reset();
        bus.req = 4'b0001;
        step();
        check("s6_pre_grant", 32'(bus.grant), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("s6_async_grant", 32'(bus.grant),    32'h0);
        check("s6_async_busy",  32'(bus.bus_busy), 32'd0);
        bus.req = 4'b0000;
        step();
        rst     = 1'b1;
        bus.req = 4'b1001;
        step();
        check("s6_ptr_reset", 32'(bus.grant), 32'h1);

        // Randomized traffic with sticky requests and occasional locks.
        do_reset();
        r = 4'b0000;
        l = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
                if ($urandom_range(0, 15) == 0) l[b] = ~l[b];
            end
            bus.req  = r;
            bus.lock = l;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
